bubble_sort_seq: RTL

BUBBLE_SORT_SEQ -- requirements
Module: bubble_sort_seq

---
 rtl/bubble_sort_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bubble_sort_seq.sv
// Sequential odd-even transposition sorter: one compare/swap pass per SORT cycle.
// Define BUBBLE_SORT_SEQ_EARLY_EXIT_EN to stop once two consecutive passes make no swaps.
module bubble_sort_seq #(
  parameter int DIM   = 4,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 descend,
  input  logic [DIM*WIDTH-1:0] prand,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIM*WIDTH-1:0] pord,
  output logic                 busy
);

  localparam int CW = $clog2(DIM) + 1;
  localparam logic [CW-1:0] LAST_PASS = CW'(DIM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        pass_q, pass_d;
  logic [DIM*WIDTH-1:0] work_q, work_d;
  logic                 desc_q, desc_d;

  logic [WIDTH-1:0]     elem [DIM];
  logic [DIM-2:0]       swap_en;
  logic [DIM*WIDTH-1:0] pass_res;

  generate
    for (genvar gi = 0; gi < DIM; gi++) begin : g_elem
      assign elem[gi] = work_q[gi*WIDTH +: WIDTH];
    end

    // Pair (gi, gi+1) participates only on passes whose parity matches gi.
    for (genvar gi = 0; gi < DIM - 1; gi++) begin : g_cmp
      localparam logic PAR = 1'(gi % 2);
      logic gt, lt;
      assign gt = elem[gi] > elem[gi+1];
      assign lt = elem[gi] < elem[gi+1];
      assign swap_en[gi] = (pass_q[0] == PAR) && (desc_q ? lt : gt);
    end

    for (genvar gi = 0; gi < DIM; gi++) begin : g_mux
      if (gi == 0) begin : g_first
        assign pass_res[gi*WIDTH +: WIDTH] = swap_en[0] ? elem[1] : elem[0];
      end else if (gi == DIM - 1) begin : g_last
        assign pass_res[gi*WIDTH +: WIDTH] = swap_en[gi-1] ? elem[gi-1] : elem[gi];
      end else begin : g_mid
        assign pass_res[gi*WIDTH +: WIDTH] = swap_en[gi]   ? elem[gi+1] :
                                             swap_en[gi-1] ? elem[gi-1] : elem[gi];
      end
    end
  endgenerate

`ifdef BUBBLE_SORT_SEQ_EARLY_EXIT_EN
  logic calm_q, calm_d;
  logic any_swap;
  assign any_swap = |swap_en;
`endif

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    work_d  = work_q;
    desc_d  = desc_q;
`ifdef BUBBLE_SORT_SEQ_EARLY_EXIT_EN
    calm_d  = calm_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = prand;
          desc_d  = descend;
          pass_d  = '0;
`ifdef BUBBLE_SORT_SEQ_EARLY_EXIT_EN
          calm_d  = 1'b0;
`endif
          state_d = SORT;
        end
      end
      SORT: begin
        work_d = pass_res;
        pass_d = pass_q + 1'b1;
`ifdef BUBBLE_SORT_SEQ_EARLY_EXIT_EN
        calm_d = ~any_swap;
        if (pass_q == LAST_PASS) begin
          state_d = DONE;
        end else if ((pass_q != '0) && calm_q && !any_swap) begin
          state_d = DONE;
        end
`else
        if (pass_q == LAST_PASS) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pass_q  <= '0;
      work_q  <= '0;
      desc_q  <= 1'b0;
`ifdef BUBBLE_SORT_SEQ_EARLY_EXIT_EN
      calm_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      work_q  <= work_d;
      desc_q  <= desc_d;
`ifdef BUBBLE_SORT_SEQ_EARLY_EXIT_EN
      calm_q  <= calm_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SORT);
  assign out_valid = (state_q == DONE);
  assign pord      = work_q;

endmodule
